// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg : shared types and helpers for the radix-4 Booth multiplier
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } sel_e;

  // Extended operand width: WIDTH+2 rounded up to the next even value.
  function automatic int calc_ew(input int width);
    return ((width + 3) / 2) * 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_r4_recoder.sv
// ---------------------------------------------------------------------------
// booth_r4_recoder : maps a {q1,q0,q_menos1} triple to a Booth digit select
// Rev 1.0          : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] triple,
  output sel_e       sel
);

  always_comb begin
    sel = ZERO;
    case (triple)
      3'b001, 3'b010: sel = P1;
      3'b011:         sel = P2;
      3'b100:         sel = M2;
      3'b101, 3'b110: sel = M1;
      default:        sel = ZERO;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/booth_r4_mul.sv
// ---------------------------------------------------------------------------
// booth_r4_mul : sequential radix-4 Booth multiplier, 2 bits per cycle,
//                signed/unsigned per operation, back-to-back issue.
//                Optional multiply-accumulate enabled by macro BOOTH_ACC_EN.
// Rev 1.0      : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module booth_r4_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicando,
  input  logic [WIDTH-1:0]   multiplicador,
`ifdef BOOTH_ACC_EN
  input  logic               accumulate,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int EW = calc_ew(WIDTH);
  localparam int N  = EW / 2;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [EW-1:0]   m_q, m_d;
  logic [EW-1:0]   q_q, q_d;
  logic [EW:0]     a_q, a_d;
  logic            qm1_q, qm1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   result_q, result_d;
`ifdef BOOTH_ACC_EN
  logic            acc_q, acc_d;
`endif

  sel_e            sel;
  logic [EW:0]     addend;
  logic [EW:0]     sum;
  logic [EW-1:0]   ext_mcand;
  logic [EW-1:0]   ext_mplier;
  logic [PW-1:0]   product;
  logic            accept;

  booth_r4_recoder u_recoder (
    .triple ({q_q[1:0], qm1_q}),
    .sel    (sel)
  );

  assign ext_mcand  = {{(EW-WIDTH){is_signed & multiplicando[WIDTH-1]}}, multiplicando};
  assign ext_mplier = {{(EW-WIDTH){is_signed & multiplicador[WIDTH-1]}}, multiplicador};
  assign accept     = start && (state_q != RUN);

  // A is one bit wider than M so that +/-2M never overflows.
  always_comb begin
    addend = '0;
    case (sel)
      P1:      addend = {m_q[EW-1], m_q};
      P2:      addend = {m_q, 1'b0};
      M1:      addend = -{m_q[EW-1], m_q};
      M2:      addend = -{m_q, 1'b0};
      default: addend = '0;
    endcase
    sum = a_q + addend;
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    q_d      = q_q;
    a_d      = a_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    product  = '0;
`ifdef BOOTH_ACC_EN
    acc_d    = acc_q;
`endif

    case (state_q)
      RUN: begin
        a_d   = {sum[EW], sum[EW], sum[EW:2]};
        q_d   = {sum[1:0], q_q[EW-1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          product = PW'({a_d[EW-1:0], q_d});
`ifdef BOOTH_ACC_EN
          result_d = acc_q ? (result_q + product) : product;
`else
          result_d = product;
`endif
        end
      end
      default: begin
        if (accept) begin
          state_d = RUN;
          m_d     = ext_mcand;
          q_d     = ext_mplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(N);
`ifdef BOOTH_ACC_EN
          acc_d   = accumulate;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      m_q      <= '0;
      q_q      <= '0;
      a_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef BOOTH_ACC_EN
      acc_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      q_q      <= q_d;
      a_q      <= a_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef BOOTH_ACC_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_r4_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_mul : scoreboard bench for booth_r4_mul (WIDTH=8 and WIDTH=5)
// Rev 1.0         : initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_booth_r4_mul;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        mon_en = 1'b0;
  logic        b2b    = 1'b0;
  logic [15:0] hold8  = '0;
  logic [15:0] hold5  = '0;
  exp_t        sb8[$];
  exp_t        sb5[$];
  exp_t        m8, m5;

  logic        start8, sgn8, acc8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        start5, sgn5, acc5, busy5, done5;
  logic [4:0]  a5, b5;
  logic [9:0]  res5;

  booth_r4_mul #(.WIDTH(8)) u_dut8 (
    .clk           (clk),
    .reset         (reset),
    .start         (start8),
    .is_signed     (sgn8),
    .multiplicando (a8),
    .multiplicador (b8),
`ifdef BOOTH_ACC_EN
    .accumulate    (acc8),
`endif
    .busy          (busy8),
    .done          (done8),
    .result        (res8)
  );

  booth_r4_mul #(.WIDTH(5)) u_dut5 (
    .clk           (clk),
    .reset         (reset),
    .start         (start5),
    .is_signed     (sgn5),
    .multiplicando (a5),
    .multiplicador (b5),
`ifdef BOOTH_ACC_EN
    .accumulate    (acc5),
`endif
    .busy          (busy5),
    .done          (done5),
    .result        (res5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_done_excl8", {31'b0, busy8 & done8}, 32'd0);
      if (b2b) check("b2b_busy8", {31'b0, busy8 | done8}, 32'd1);
      if (done8) begin
        if (sb8.size() == 0) begin
          check("unexpected_done8", 32'd1, 32'd0);
        end else begin
          m8 = sb8.pop_front();
          check("result8", {16'b0, res8}, {16'b0, m8.res});
          check("latency8", cyc - m8.cyc, 32'd5);
          hold8 = m8.res;
        end
      end else begin
        check("hold8", {16'b0, res8}, {16'b0, hold8});
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (done5) begin
        if (sb5.size() == 0) begin
          check("unexpected_done5", 32'd1, 32'd0);
        end else begin
          m5 = sb5.pop_front();
          check("result5", {22'b0, res5}, {16'b0, m5.res});
          check("latency5", cyc - m5.cyc, 32'd4);
          hold5 = m5.res;
        end
      end else begin
        check("hold5", {22'b0, res5}, {16'b0, hold5});
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic acc, input logic [15:0] exp);
    exp_t e;
    a8 = a; b8 = b; sgn8 = s; acc8 = acc; start8 = 1'b1;
    @(posedge clk); #1;
    e.res = exp; e.cyc = cyc;
    sb8.push_back(e);
    start8 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic issue5(input logic [4:0] a, input logic [4:0] b, input logic s,
                        input logic [9:0] exp);
    exp_t e;
    a5 = a; b5 = b; sgn5 = s; start5 = 1'b1;
    @(posedge clk); #1;
    e.res = {6'b0, exp}; e.cyc = cyc;
    sb5.push_back(e);
    start5 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  logic [7:0]  va[4] = '{8'hFF, 8'h64, 8'h7F, 8'hC8};
  logic [7:0]  vb[4] = '{8'h01, 8'hFE, 8'h7F, 8'h03};
  logic        vs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] ve[4] = '{16'hFFFF, 16'hFF38, 16'h3F01, 16'h0258};

  initial begin
    exp_t e;
    reset = 1'b1;
    start8 = 0; sgn8 = 0; acc8 = 0; a8 = 0; b8 = 0;
    start5 = 0; sgn5 = 0; acc5 = 0; a5 = 0; b5 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy8", {31'b0, busy8}, 32'd0);
    check("reset_done8", {31'b0, done8}, 32'd0);
    check("reset_result8", {16'b0, res8}, 32'd0);
    check("reset_result5", {22'b0, res5}, 32'd0);
    mon_en = 1'b1;

    issue8(8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1);   // -3 * 5
    issue8(8'h80, 8'h80, 1'b1, 1'b0, 16'h4000);   // -128 * -128
    issue8(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);   // 255 * 255
    issue8(8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0001);   // -1 * -1

    issue5(5'h10, 5'h0F, 1'b1, 10'h310);          // -16 * 15
    issue5(5'h1F, 5'h1F, 1'b0, 10'h3C1);          // 31 * 31
    issue5(5'h1F, 5'h1F, 1'b1, 10'h001);          // -1 * -1

    // start held high; operands scrambled while the multiplier is running
    start8 = 1'b1; acc8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a8 = va[i]; b8 = vb[i]; sgn8 = vs[i];
      @(posedge clk); #1;
      e.res = ve[i]; e.cyc = cyc;
      sb8.push_back(e);
      b2b = 1'b1;
      for (int j = 0; j < 5; j++) begin
        a8 = a8 + 8'd37; b8 = ~b8; sgn8 = ~sgn8;
        @(posedge clk); #1;
      end
    end
    start8 = 1'b0;
    b2b = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // abort three cycles into an operation
    a8 = 8'd7; b8 = 8'd9; sgn8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hold8 = '0;
    hold5 = '0;
    check("abort_busy8", {31'b0, busy8}, 32'd0);
    check("abort_done8", {31'b0, done8}, 32'd0);
    check("abort_result8", {16'b0, res8}, 32'd0);
    repeat (10) @(posedge clk);
    #1;

`ifdef BOOTH_ACC_EN
    issue8(8'd10,  8'd10,  1'b0, 1'b0, 16'h0064);
    issue8(8'd20,  8'd3,   1'b0, 1'b1, 16'h00A0);
    issue8(8'd16,  8'd32,  1'b0, 1'b0, 16'h0200);
    issue8(8'hFF,  8'hFF,  1'b0, 1'b1, 16'h0001);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb8_drained", sb8.size(), 32'd0);
    check("sb5_drained", sb5.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
